// File: rtl/anim_sequencer.sv
// Seven-segment animation sequencer. A prescaled tick steps the frame within the
// current animation. mode_pulse selects the next animation and restarts its timing.
module anim_sequencer #(
    parameter int PRESCALE = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic       mode_pulse,
    input  logic [1:0] speed,
    input  logic       dir,
    input  logic       pause,
    output logic [6:0] seg,
    output logic [1:0] mode,
    output logic [3:0] frame,
    output logic       tick
);

    localparam logic [27:0] PRESCALE_W = 28'(PRESCALE);

    logic [25:0] counter_reg, counter_next;
    logic [1:0]  mode_reg, mode_next;
    logic [3:0]  frame_reg, frame_next;
    logic        tick_reg, tick_next;
    logic [6:0]  seg_reg, seg_next;

    logic        running;
    logic [27:0] tc;
    logic        at_tc;
    logic [3:0]  last_frame;

    function automatic logic [3:0] frame_last(input logic [1:0] m);
        case (m)
            2'd0:    frame_last = 4'd5;
            2'd1:    frame_last = 4'd7;
            2'd2:    frame_last = 4'd9;
            default: frame_last = 4'd1;
        endcase
    endfunction

    function automatic logic [6:0] seg_lut(input logic [1:0] m, input logic [3:0] f);
        logic [6:0] s;
        s = 7'h00;
        case (m)
            2'd0: case (f)
                4'd0: s = 7'h01;  4'd1: s = 7'h02;  4'd2: s = 7'h04;
                4'd3: s = 7'h08;  4'd4: s = 7'h10;  4'd5: s = 7'h20;
                default: s = 7'h00;
            endcase
            2'd1: case (f)
                4'd0: s = 7'h01;  4'd1: s = 7'h02;  4'd2: s = 7'h40;  4'd3: s = 7'h10;
                4'd4: s = 7'h08;  4'd5: s = 7'h04;  4'd6: s = 7'h40;  4'd7: s = 7'h20;
                default: s = 7'h00;
            endcase
            2'd2: case (f)
                4'd0: s = 7'h3F;  4'd1: s = 7'h06;  4'd2: s = 7'h5B;  4'd3: s = 7'h4F;
                4'd4: s = 7'h66;  4'd5: s = 7'h6D;  4'd6: s = 7'h7D;  4'd7: s = 7'h07;
                4'd8: s = 7'h7F;  4'd9: s = 7'h6F;
                default: s = 7'h00;
            endcase
            default: case (f)
                4'd0: s = 7'h7F;
                default: s = 7'h00;
            endcase
        endcase
        return s;
    endfunction

    // Terminal count is recomputed every cycle so a speed change applies at once.
    assign tc         = PRESCALE_W * (28'd4 - 28'(speed)) - 28'd1;
    assign at_tc      = {2'b00, counter_reg} >= tc;
    assign running    = ena && !pause;
    assign last_frame = frame_last(mode_reg);

    always_comb begin
        counter_next = counter_reg;
        mode_next    = mode_reg;
        frame_next   = frame_reg;
        tick_next    = 1'b0;
        if (ena && mode_pulse) begin
            mode_next    = mode_reg + 2'd1;
            frame_next   = 4'd0;
            counter_next = '0;
        end else if (running) begin
            if (at_tc) begin
                counter_next = '0;
                tick_next    = 1'b1;
                if (dir)
                    frame_next = (frame_reg == 4'd0) ? last_frame : frame_reg - 4'd1;
                else
                    frame_next = (frame_reg == last_frame) ? 4'd0 : frame_reg + 4'd1;
            end else begin
                counter_next = counter_reg + 26'd1;
            end
        end
        // Decode from the next state so seg lines up with mode/frame on the same edge.
        seg_next = seg_lut(mode_next, frame_next);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            counter_reg <= '0;
            mode_reg    <= 2'd0;
            frame_reg   <= 4'd0;
            tick_reg    <= 1'b0;
            seg_reg     <= 7'h01;
        end else begin
            counter_reg <= counter_next;
            mode_reg    <= mode_next;
            frame_reg   <= frame_next;
            tick_reg    <= tick_next;
            seg_reg     <= seg_next;
        end
    end

    assign seg   = seg_reg;
    assign mode  = mode_reg;
    assign frame = frame_reg;
    assign tick  = tick_reg;

endmodule

// File: doc/anim_sequencer.md
ANIM_SEQUENCER -- requirements
Module: anim_sequencer

Interface
REQ-001 The block SHALL have parameter PRESCALE, default 4, meaning base tick period in clk cycles; legal range 1..2^24.
REQ-002 The block SHALL have port clk  input  1  system clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n  input  1  reset; one clock, reset asynchronous and active-low.
REQ-004 The block SHALL have port ena  input  1  design enable; low freezes all state.
REQ-005 The block SHALL have port mode_pulse  input  1  single-cycle pulse, already synchronized and debounced, selecting the next animation.
REQ-006 The block SHALL have port speed  input  2  animation rate select; 3 = fastest.
REQ-007 The block SHALL have port dir  input  1  frame direction: 0 = forward, 1 = reverse.
REQ-008 The block SHALL have port pause  input  1  level; high holds frame and prescaler.
REQ-009 The block SHALL have port seg  output  7  active-high segment pattern, bit0 = a through bit6 = g.
REQ-010 The block SHALL have port mode  output  2  current animation index.
REQ-011 The block SHALL have port frame  output  4  current frame index.
REQ-012 The block SHALL have port tick  output  1  one-cycle pulse on each frame advance.

Function
REQ-013 Run condition: ena=1 and pause=0; otherwise prescaler, frame, mode and tick hold, with tick forced to 0.
REQ-014 Prescaler: 26-bit counter; terminal count TC = PRESCALE*(4-speed)-1; counter increments while running.
REQ-015 On a running cycle with counter >= TC: counter clears to 0, tick=1 next cycle, frame advances on the same edge.
REQ-016 A speed change mid-count takes effect immediately; if counter already >= new TC, the advance occurs on the next running edge.
REQ-017 Frame count per mode: mode0 spin = 6, mode1 figure-8 = 8, mode2 digits = 10, mode3 blink = 2.
REQ-018 Forward advance: frame+1, wrapping last->0; reverse advance: frame-1, wrapping 0->last.
REQ-019 Mode0 seg by frame: 01,02,04,08,10,20 (hex).
REQ-020 Mode1 seg by frame: 01,02,40,10,08,04,40,20.
REQ-021 Mode2 seg by frame: 3F,06,5B,4F,66,6D,7D,07,7F,6F.
REQ-022 Mode3 seg by frame: 7F,00.
REQ-023 seg SHALL be a registered output matching the table entry for the current mode/frame registers, with no extra cycle of lag.
REQ-024 mode_pulse with ena=1, regardless of pause: mode advances 0->1->2->3->0, frame=0, counter=0, no tick that cycle.
REQ-025 mode_pulse coincident with a terminal count: mode_pulse wins and the frame advance is discarded.
REQ-026 mode_pulse with ena=0 SHALL be ignored.
REQ-027 A dir change affects only subsequent advances; the current frame is unchanged.

Reset
REQ-028 While rst_n=0, regardless of clk: mode=0, frame=0, counter=0, tick=0, seg=7'h01.
REQ-029 Reset asserted mid-operation SHALL abort any pending advance; the first tick after release occurs TC+1 running cycles later.

Verification
REQ-030 Reset then release, speed=3, PRESCALE=4 -> seg=01 for 4 cycles; tick on cycle 5; frame=1; seg=02.
REQ-031 speed=0 -> ticks every 16 cycles; in mode0, 6 ticks return frame to 0 and seg to 01.
REQ-032 Two mode_pulses -> mode=2, frame=0, seg=3F; dir=1 then one tick -> frame=9, seg=6F.
REQ-033 pause=1 for 20 cycles -> no tick, frame held; pause=0 -> counter resumes from its held value.
REQ-034 mode_pulse on the terminal-count cycle in mode3 at frame 1 -> mode=0, frame=0, seg=01, tick=0.
REQ-035 rst_n low for 1 cycle mid-count in mode1 frame 5 -> immediately seg=01, mode=0, frame=0; next tick TC+1 cycles after release.
